// File: rtl/cht_word_deserializer.sv
// cht_word_deserializer: rebuilds WIDTH-bit words from a serial bit stream.
// Bits arrive on a bit_valid/bit_ready handshake. Assembled words leave on a
// word_valid/word_ready handshake. Shift direction is latched on the first
// bit of each word.
// Optional feature macro: CHT_DESER_PARITY_EN. When it is defined, each word is
// followed by an even-parity bit and parity_err reports the check result.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid & ready are both 1. Once valid is raised it stays high, with its
// data stable, until that transfer. clr is the one exception: it drops a
// pending word without a transfer.
module cht_word_deserializer #(
  parameter int WIDTH   = 16,
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               msb_first,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               bit_ready,
  output logic               word_valid,
  output logic [WIDTH-1:0]   word_data,
  input  logic               word_ready,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   word_data_q, word_data_d;
  logic [CW-1:0]      count_q, count_d;
  logic               dir_q, dir_d;
  logic               word_valid_q, word_valid_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               perr_q, perr_d;

  logic               commit_bit;
  logic               accept;
  logic               dir_use;
  logic [WIDTH-1:0]   shreg_nx;

  // Stall decode: is the next accepted bit the one that commits a word?
  always_comb begin
`ifdef CHT_DESER_PARITY_EN
    commit_bit = (state_q == PAR);
`else
    commit_bit = (state_q == DATA) && (count_q == CW'(WIDTH - 1));
`endif
    // Only the commit bit waits, so exactly one finished word is buffered.
    // A clear or reset always takes the offered bit, and that bit is then dropped.
    bit_ready = !rst_n || clr || !(commit_bit && word_valid_q && !word_ready);
    accept    = bit_valid && bit_ready && !clr;
    dir_use   = (state_q == IDLE) ? msb_first : dir_q;
    shreg_nx  = dir_use ? {shreg_q[WIDTH-2:0], bit_in} : {bit_in, shreg_q[WIDTH-1:1]};
  end

  // Next-state logic: FSM, shift register, output word and stall counter.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    word_data_d  = word_data_q;
    count_d      = count_q;
    dir_d        = dir_q;
    word_valid_d = word_valid_q;
    stall_d      = stall_q;
    perr_d       = perr_q;

    if (word_valid_q && word_ready) word_valid_d = 1'b0;

    if (bit_valid && !bit_ready && !(&stall_q)) stall_d = stall_q + 1'b1;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          dir_d   = msb_first;
          shreg_d = shreg_nx;
          count_d = CW'(1);
          state_d = DATA;
        end
        DATA: begin
          shreg_d = shreg_nx;
          count_d = count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            count_d = '0;
`ifdef CHT_DESER_PARITY_EN
            state_d = PAR;
`else
            word_data_d  = shreg_nx;
            word_valid_d = 1'b1;
            state_d      = IDLE;
`endif
          end
        end
        PAR: begin
          // Even parity: the data bits plus the parity bit must XOR to 0.
          word_data_d  = shreg_q;
          word_valid_d = 1'b1;
          perr_d       = ^{shreg_q, bit_in};
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (clr) begin
      state_d      = IDLE;
      shreg_d      = '0;
      word_data_d  = '0;
      count_d      = '0;
      dir_d        = 1'b0;
      word_valid_d = 1'b0;
      stall_d      = '0;
      perr_d       = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      word_data_q  <= '0;
      count_q      <= '0;
      dir_q        <= 1'b0;
      word_valid_q <= 1'b0;
      stall_q      <= '0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      word_data_q  <= word_data_d;
      count_q      <= count_d;
      dir_q        <= dir_d;
      word_valid_q <= word_valid_d;
      stall_q      <= stall_d;
      perr_q       <= perr_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign stall_cnt  = stall_q;
`ifdef CHT_DESER_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_cht_word_deserializer.sv
// Bench for cht_word_deserializer: a vector table, hand-written corner
// sequences and a scoreboard queue popped on every word handshake.
module tb_cht_word_deserializer;

  localparam int WIDTH   = 16;
  localparam int STALL_W = 8;

  logic               clk = 1'b0;
  logic               rst_n, clr, msb_first, bit_valid, bit_in, word_ready;
  logic               bit_ready, word_valid, parity_err;
  logic [WIDTH-1:0]   word_data;
  logic [STALL_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             bits_q[$];
  logic             msbs_q[$];

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             msb;
    logic             toggle;
    logic [WIDTH-1:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  cht_word_deserializer #(.WIDTH(WIDTH), .STALL_W(STALL_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .msb_first(msb_first),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .stall_cnt(stall_cnt), .parity_err(parity_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every word handshake pops one expected word.
  always @(negedge clk) begin
    if (rst_n && !clr && word_valid && word_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL word_unexpected: got %0h expected none", word_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (word_data !== e) begin
          bad++;
          $display("FAIL word_data: got %0h expected %0h", word_data, e);
        end
      end
    end
  end

  // Build the serial stream for one word (plus parity bit when enabled).
  task automatic build_bits(input logic [WIDTH-1:0] d, input logic m, input logic tog,
                            input logic flip);
    bits_q.delete();
    msbs_q.delete();
    for (int i = 0; i < WIDTH; i++) begin
      bits_q.push_back(m ? d[WIDTH-1-i] : d[i]);
      msbs_q.push_back((tog && i > 0) ? (m ^ i[0]) : m);
    end
`ifdef CHT_DESER_PARITY_EN
    bits_q.push_back((^d) ^ flip);
    msbs_q.push_back(~m);
`else
    if (flip) msbs_q[0] = m;
`endif
  endtask

  // Offer one bit and wait (bounded) until it is accepted.
  task automatic send_bit(input logic b, input logic m);
    int n;
    n = 0;
    bit_valid = 1'b1;
    bit_in    = b;
    msb_first = m;
    @(negedge clk);
    while (!bit_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bit_ready) begin
      total++;
      bad++;
      $display("FAIL bit_accept_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_bit(bits_q[i], msbs_q[i]);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input logic m, input logic tog,
                           input logic flip);
    build_bits(d, m, tog, flip);
    exp_q.push_back(d);
    send_range(0, bits_q.size() - 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || word_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 1'b1, 1'b0, 16'hA5C3};
    vecs[1] = '{16'hA5C3, 1'b0, 1'b0, 16'hA5C3};
    vecs[2] = '{16'hA5C3, 1'b0, 1'b1, 16'hA5C3};
    vecs[3] = '{16'h8001, 1'b1, 1'b1, 16'h8001};
    vecs[4] = '{16'hFFFF, 1'b0, 1'b0, 16'hFFFF};
    vecs[5] = '{16'h0000, 1'b1, 1'b0, 16'h0000};

    rst_n = 1'b0; clr = 1'b0; msb_first = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    word_ready = 1'b1;

    // Reset with bit_valid held
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bit_valid = 1'b0;
    @(negedge clk);
    check("rst_word_valid", word_valid, 0);
    check("rst_word_data", word_data, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_bit_ready", bit_ready, 1);
    check("rst_parity_err", parity_err, 0);
    @(posedge clk);
    #1;

    // Table of words: direction and mid-word msb_first toggling
    for (int v = 0; v < 6; v++) begin
      check("pre_word_valid", word_valid, 0);
      exp_q.push_back(vecs[v].exp_word);
      build_bits(vecs[v].data, vecs[v].msb, vecs[v].toggle, 1'b0);
      send_range(0, bits_q.size() - 1);
      check("word_valid_after_last_bit", word_valid, 1);
      check("parity_err_good", parity_err, 0);
      drain();
    end

    // Random words streamed back to back
    for (int r = 0; r < 8; r++) begin
      logic [WIDTH-1:0] d;
      d = WIDTH'($urandom_range(0, 65535));
      send_word(d, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    drain();

    // Back-pressure: second word's commit bit stalls for 5 cycles
    word_ready = 1'b0;
    send_word(16'h1234, 1'b1, 1'b0, 1'b0);
    check("bp_first_valid", word_valid, 1);
    build_bits(16'hBEEF, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(16'hBEEF);
    send_range(0, bits_q.size() - 2);
    bit_valid = 1'b1;
    bit_in    = bits_q[bits_q.size() - 1];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_bit_ready_low", bit_ready, 0);
      @(posedge clk);
      #1;
    end
    check("bp_stall_cnt", stall_cnt, 5);
    check("bp_data_held", word_data, 16'h1234);
    word_ready = 1'b1;
    @(negedge clk);
    check("bp_bit_ready_release", bit_ready, 1);
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    check("bp_second_valid", word_valid, 1);
    drain();
    check("bp_stall_cnt_hold", stall_cnt, 5);

    // Clear mid-word, then a clean word
    build_bits(16'hFFFF, 1'b1, 1'b0, 1'b0);
    send_range(0, 6);
    clr = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    @(negedge clk);
    check("clr_bit_ready", bit_ready, 1);
    @(posedge clk);
    #1;
    clr = 1'b0;
    bit_valid = 1'b0;
    check("clr_stall_cnt", stall_cnt, 0);
    send_word(16'h0001, 1'b1, 1'b0, 1'b0);
    drain();

    // Clear drops a pending word
    word_ready = 1'b0;
    build_bits(16'h5A5A, 1'b1, 1'b0, 1'b0);
    send_range(0, bits_q.size() - 1);
    check("pend_valid", word_valid, 1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    word_ready = 1'b1;
    @(negedge clk);
    check("pend_dropped_valid", word_valid, 0);
    check("pend_dropped_data", word_data, 0);

`ifdef CHT_DESER_PARITY_EN
    // Parity check on 0003
    send_word(16'h0003, 1'b1, 1'b0, 1'b0);
    check("parity_ok", parity_err, 0);
    drain();
    send_word(16'h0003, 1'b1, 1'b0, 1'b1);
    check("parity_bad", parity_err, 1);
    drain();
    check("parity_bad_held", parity_err, 1);
`endif

    repeat (3) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
